wb_ooo_slave: RTL

Wishbone responder (slave end) that accepts pipelined, tagged requests and completes them out of order. Each accepted request sits in a small outstanding-request buffer with an address-dependent latency and is answered with its own tag. The block owns a local word memory and is the target the out-of-order Wishbone master agent is verified against. Requests arriving while the buffer is full are refused with RTY.

---
 rtl/wb_ooo_slave.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/wb_ooo_slave.sv
// wb_ooo_slave: Wishbone responder with tagged, pipelined requests that
// complete out of order. Accepted requests wait in a small slot buffer
// for an address-dependent latency (1/3/5/7 cycles from ADR_I[1:0]).
// A termination returns the tag of the request it ends. The block owns
// a local word memory. A request that arrives while every slot is busy
// is refused with RTY.
//
// Ports:
//   CLK_I, RST_I          clock, asynchronous active-high reset
//   CYC_I, STB_I, WE_I    cycle, strobe, write enable
//   ADR_I, DAT_I, SEL_I   word address, write data, byte enables
//   TGA_I                 request tag
//   DAT_O, TGD_O          read data, tag of the terminated request
//   ACK_O, ERR_O, RTY_O   normal termination, out-of-range termination, refusal
module wb_ooo_slave #(
  parameter int DAT_W     = 32,
  parameter int ADR_W     = 8,
  parameter int TAG_W     = 4,
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 16
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               CYC_I,
  input  logic               STB_I,
  input  logic               WE_I,
  input  logic [ADR_W-1:0]   ADR_I,
  input  logic [DAT_W-1:0]   DAT_I,
  input  logic [DAT_W/8-1:0] SEL_I,
  input  logic [TAG_W-1:0]   TGA_I,
  output logic [DAT_W-1:0]   DAT_O,
  output logic [TAG_W-1:0]   TGD_O,
  output logic               ACK_O,
  output logic               ERR_O,
  output logic               RTY_O
);

  localparam int SEL_W  = DAT_W / 8;
  localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MIDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADR_W:0] MEM_LIMIT = (ADR_W + 1)'(MEM_WORDS);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] slot_we;
  logic [TAG_W-1:0] slot_tag [DEPTH];
  logic [ADR_W-1:0] slot_adr [DEPTH];
  logic [DAT_W-1:0] slot_dat [DEPTH];
  logic [SEL_W-1:0] slot_sel [DEPTH];
  logic [2:0]       slot_cnt [DEPTH];
  logic [DAT_W-1:0] mem [MEM_WORDS];

  logic              req;
  logic              refuse;
  logic              have_free;
  logic              have_ready;
  logic              in_range;
  logic [SLOT_W-1:0] free_idx;
  logic [SLOT_W-1:0] sel_idx;
  logic [MIDX_W-1:0] sel_word;

  // Downward scans so the lowest free / lowest ready index wins.
  always_comb begin
    req        = CYC_I & STB_I;
    have_free  = 1'b0;
    have_ready = 1'b0;
    free_idx   = '0;
    sel_idx    = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (!valid[i-1]) begin
        have_free = 1'b1;
        free_idx  = SLOT_W'(i - 1);
      end
      if (valid[i-1] && slot_cnt[i-1] == '0) begin
        have_ready = 1'b1;
        sel_idx    = SLOT_W'(i - 1);
      end
    end
    // Fullness is judged on the slot state before this edge, so a slot
    // terminating on this edge still counts as busy.
    refuse   = req & ~have_free;
    in_range = {1'b0, slot_adr[sel_idx]} < MEM_LIMIT;
    sel_word = slot_adr[sel_idx][MIDX_W-1:0];
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      valid   <= '0;
      slot_we <= '0;
      DAT_O   <= '0;
      TGD_O   <= '0;
      ACK_O   <= 1'b0;
      ERR_O   <= 1'b0;
      RTY_O   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_tag[i] <= '0;
        slot_adr[i] <= '0;
        slot_dat[i] <= '0;
        slot_sel[i] <= '0;
        slot_cnt[i] <= '0;
      end
      for (int unsigned w = 0; w < MEM_WORDS; w++) begin
        mem[w] <= '0;
      end
    end else begin
      DAT_O <= '0;
      TGD_O <= '0;
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      RTY_O <= 1'b0;
      if (!CYC_I) begin
        valid <= '0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (valid[i] && slot_cnt[i] != '0) begin
            slot_cnt[i] <= slot_cnt[i] - 3'd1;
          end
        end
        if (refuse) begin
          RTY_O <= 1'b1;
          TGD_O <= TGA_I;
        end else if (have_ready) begin
          valid[sel_idx] <= 1'b0;
          TGD_O          <= slot_tag[sel_idx];
          if (!in_range) begin
            ERR_O <= 1'b1;
          end else begin
            ACK_O <= 1'b1;
            if (slot_we[sel_idx]) begin
              for (int unsigned b = 0; b < SEL_W; b++) begin
                if (slot_sel[sel_idx][b]) begin
                  mem[sel_word][8*b +: 8] <= slot_dat[sel_idx][8*b +: 8];
                end
              end
            end else begin
              DAT_O <= mem[sel_word];
            end
          end
        end
        if (req && have_free) begin
          valid[free_idx]    <= 1'b1;
          slot_we[free_idx]  <= WE_I;
          slot_tag[free_idx] <= TGA_I;
          slot_adr[free_idx] <= ADR_I;
          slot_dat[free_idx] <= DAT_I;
          slot_sel[free_idx] <= SEL_I;
          // Stored as latency-1 (0,2,4,6): a slot with zero count is
          // selectable on the next edge, giving 1/3/5/7 cycles overall.
          slot_cnt[free_idx] <= {ADR_I[1:0], 1'b0};
        end
      end
    end
  end

endmodule
